// File: rtl/bytecode_pkg.sv
// Shared definitions for the bytecode core: opcode values, ALU op encoding,
// branch-condition encoding and the registered decode record.
package bytecode_pkg;

  localparam logic [7:0] OP_ICONST_M1 = 8'h02;
  localparam logic [7:0] OP_ICONST_5  = 8'h08;
  localparam logic [7:0] OP_BIPUSH    = 8'h10;
  localparam logic [7:0] OP_SIPUSH    = 8'h11;
  localparam logic [7:0] OP_IADD      = 8'h60;
  localparam logic [7:0] OP_ISUB      = 8'h64;
  localparam logic [7:0] OP_IMUL      = 8'h68;
  localparam logic [7:0] OP_IDIV      = 8'h6c;
  localparam logic [7:0] OP_IREM      = 8'h70;
  localparam logic [7:0] OP_INEG      = 8'h74;
  localparam logic [7:0] OP_ISHL      = 8'h78;
  localparam logic [7:0] OP_ISHR      = 8'h7a;
  localparam logic [7:0] OP_IUSHR     = 8'h7c;
  localparam logic [7:0] OP_IAND      = 8'h7e;
  localparam logic [7:0] OP_IOR       = 8'h80;
  localparam logic [7:0] OP_IXOR      = 8'h82;
  localparam logic [7:0] OP_IFEQ      = 8'h99;
  localparam logic [7:0] OP_IFNE      = 8'h9a;
  localparam logic [7:0] OP_IFLT      = 8'h9b;
  localparam logic [7:0] OP_IFGE      = 8'h9c;
  localparam logic [7:0] OP_IFGT      = 8'h9d;
  localparam logic [7:0] OP_IFLE      = 8'h9e;
  localparam logic [7:0] OP_IF_ICMPEQ = 8'h9f;
  localparam logic [7:0] OP_IF_ICMPNE = 8'ha0;
  localparam logic [7:0] OP_IF_ICMPLT = 8'ha1;
  localparam logic [7:0] OP_IF_ICMPGE = 8'ha2;
  localparam logic [7:0] OP_IF_ICMPGT = 8'ha3;
  localparam logic [7:0] OP_IF_ICMPLE = 8'ha4;
  localparam logic [7:0] OP_GOTO      = 8'ha7;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MUL  = 4'd2,
    ALU_DIV  = 4'd3,
    ALU_REM  = 4'd4,
    ALU_NEG  = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_SHR  = 4'd7,
    ALU_USHR = 4'd8,
    ALU_AND  = 4'd9,
    ALU_OR   = 4'd10,
    ALU_XOR  = 4'd11
  } alu_op_t;

  typedef enum logic [2:0] {
    CMP_EQ = 3'd0,
    CMP_NE = 3'd1,
    CMP_LT = 3'd2,
    CMP_LE = 3'd3,
    CMP_GE = 3'd4,
    CMP_GT = 3'd5
  } cmp_t;

  typedef struct packed {
    alu_op_t     aluop;
    logic        isaluop;
    logic        iscmp;
    logic [3:0]  cmptype;
    logic        isargpush;
    logic        isgoto;
    logic [1:0]  argc;
    logic [1:0]  stackargs;
    logic        stackwb;
    logic        constpush;
    logic [31:0] constval;
  } decode_t;

endpackage

// File: rtl/bytecode_exec_unit_if.sv
// Opcode/operand bus into the exec unit and its registered decode/ALU outputs.
// No handshake: a new op_code/operand set is consumed on every enabled edge.
interface bytecode_exec_unit_if;
  logic [7:0]  op_code;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  aluop;
  logic        isaluop;
  logic        iscmp;
  logic [3:0]  cmptype;
  logic        isargpush;
  logic        isgoto;
  logic [1:0]  argc;
  logic [1:0]  stackargs;
  logic        stackwb;
  logic        constpush;
  logic [31:0] constval;
  logic [31:0] result_lo;
  logic [31:0] result_hi;

  modport master (
    output op_code, operand_a, operand_b,
    input  aluop, isaluop, iscmp, cmptype, isargpush, isgoto, argc,
           stackargs, stackwb, constpush, constval, result_lo, result_hi
  );

  modport slave (
    input  op_code, operand_a, operand_b,
    output aluop, isaluop, iscmp, cmptype, isargpush, isgoto, argc,
           stackargs, stackwb, constpush, constval, result_lo, result_hi
  );
endinterface

// File: rtl/bytecode_exec_unit_int_alu.sv
// Combinational 32-bit signed integer ALU with JVM division semantics.
module int_alu
  import bytecode_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  logic signed [31:0] sa, sb, sb_safe, quot, rem, sra;
  logic signed [63:0] prod;
  logic               div_zero;
  logic [4:0]         sh;

  assign sa       = a;
  assign sb       = b;
  assign sh       = b[4:0];
  assign div_zero = (b == 32'd0);
  // INT_MIN / -1 is steered to a divide by 1, which gives exactly the
  // required INT_MIN quotient and zero remainder without overflow.
  assign sb_safe  = (div_zero || (a == 32'h8000_0000 && b == 32'hffff_ffff))
                    ? 32'sd1 : sb;
  assign quot     = sa / sb_safe;
  assign rem      = sa % sb_safe;
  assign sra      = sa >>> sh;
  assign prod     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

  always_comb begin
    lo = '0;
    hi = '0;
    case (op)
      ALU_ADD:  lo = a + b;
      ALU_SUB:  lo = a - b;
      ALU_MUL:  {hi, lo} = prod;
      ALU_DIV: begin
        lo = div_zero ? 32'd0 : quot;
        hi = div_zero ? 32'd0 : rem;
      end
      ALU_REM:  lo = div_zero ? 32'd0 : rem;
      ALU_NEG:  lo = 32'd0 - a;
      ALU_SHL:  lo = a << sh;
      ALU_SHR:  lo = sra;
      ALU_USHR: lo = a >> sh;
      ALU_AND:  lo = a & b;
      ALU_OR:   lo = a | b;
      ALU_XOR:  lo = a ^ b;
      default:  lo = '0;
    endcase
  end

endmodule

// File: rtl/bytecode_exec_unit.sv
// Registered bytecode decode plus integer ALU stage; every output appears one
// clock after op_code/operands are presented.
module bytecode_exec_unit
  import bytecode_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  bytecode_exec_unit_if.slave bus
);

  logic    alu_hit, br_hit, br_vs_b;
  alu_op_t alu_sel;
  cmp_t    br_cond;
  decode_t dec_d, dec_q;
  logic [31:0] lo_d, hi_d, lo_q, hi_q;

  always_comb begin
    alu_hit = 1'b1;
    alu_sel = ALU_ADD;
    unique case (bus.op_code)
      OP_IADD:  alu_sel = ALU_ADD;
      OP_ISUB:  alu_sel = ALU_SUB;
      OP_IMUL:  alu_sel = ALU_MUL;
      OP_IDIV:  alu_sel = ALU_DIV;
      OP_IREM:  alu_sel = ALU_REM;
      OP_INEG:  alu_sel = ALU_NEG;
      OP_ISHL:  alu_sel = ALU_SHL;
      OP_ISHR:  alu_sel = ALU_SHR;
      OP_IUSHR: alu_sel = ALU_USHR;
      OP_IAND:  alu_sel = ALU_AND;
      OP_IOR:   alu_sel = ALU_OR;
      OP_IXOR:  alu_sel = ALU_XOR;
      default:  alu_hit = 1'b0;
    endcase
  end

  always_comb begin
    br_hit  = 1'b1;
    br_vs_b = 1'b0;
    br_cond = CMP_EQ;
    unique case (bus.op_code)
      OP_IFEQ:      br_cond = CMP_EQ;
      OP_IFNE:      br_cond = CMP_NE;
      OP_IFLT:      br_cond = CMP_LT;
      OP_IFGE:      br_cond = CMP_GE;
      OP_IFGT:      br_cond = CMP_GT;
      OP_IFLE:      br_cond = CMP_LE;
      OP_IF_ICMPEQ: begin br_vs_b = 1'b1; br_cond = CMP_EQ; end
      OP_IF_ICMPNE: begin br_vs_b = 1'b1; br_cond = CMP_NE; end
      OP_IF_ICMPLT: begin br_vs_b = 1'b1; br_cond = CMP_LT; end
      OP_IF_ICMPGE: begin br_vs_b = 1'b1; br_cond = CMP_GE; end
      OP_IF_ICMPGT: begin br_vs_b = 1'b1; br_cond = CMP_GT; end
      OP_IF_ICMPLE: begin br_vs_b = 1'b1; br_cond = CMP_LE; end
      default:      br_hit = 1'b0;
    endcase
  end

  always_comb begin
    dec_d = '0;
    if (alu_hit) begin
      dec_d.aluop     = alu_sel;
      dec_d.isaluop   = 1'b1;
      dec_d.stackwb   = 1'b1;
      dec_d.stackargs = (alu_sel == ALU_NEG) ? 2'd1 : 2'd2;
    end else if (br_hit) begin
      dec_d.iscmp     = 1'b1;
      dec_d.cmptype   = {br_vs_b, br_cond};
      dec_d.stackargs = br_vs_b ? 2'd2 : 2'd1;
      dec_d.argc      = 2'd2;
    end else if (bus.op_code >= OP_ICONST_M1 && bus.op_code <= OP_ICONST_5) begin
      dec_d.constpush = 1'b1;
      dec_d.stackwb   = 1'b1;
      // iconst_m1 (0x02) maps to -1, so the value is opcode minus 3.
      dec_d.constval  = {24'd0, bus.op_code} - 32'd3;
    end else if (bus.op_code == OP_BIPUSH || bus.op_code == OP_SIPUSH) begin
      dec_d.isargpush = 1'b1;
      dec_d.stackwb   = 1'b1;
      dec_d.argc      = (bus.op_code == OP_SIPUSH) ? 2'd2 : 2'd1;
    end else if (bus.op_code == OP_GOTO) begin
      dec_d.isgoto    = 1'b1;
      dec_d.argc      = 2'd2;
    end
  end

  int_alu u_alu (
    .a  (bus.operand_a),
    .b  (bus.operand_b),
    .op (dec_d.aluop),
    .lo (lo_d),
    .hi (hi_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_q <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
    end else begin
      dec_q <= dec_d;
      lo_q  <= lo_d;
      hi_q  <= hi_d;
    end
  end

  assign bus.aluop     = dec_q.aluop;
  assign bus.isaluop   = dec_q.isaluop;
  assign bus.iscmp     = dec_q.iscmp;
  assign bus.cmptype   = dec_q.cmptype;
  assign bus.isargpush = dec_q.isargpush;
  assign bus.isgoto    = dec_q.isgoto;
  assign bus.argc      = dec_q.argc;
  assign bus.stackargs = dec_q.stackargs;
  assign bus.stackwb   = dec_q.stackwb;
  assign bus.constpush = dec_q.constpush;
  assign bus.constval  = dec_q.constval;
  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;

endmodule

// File: tb/tb_bytecode_exec_unit.sv
// Directed bench for bytecode_exec_unit: hand-computed decode and ALU results.
module tb_bytecode_exec_unit;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  bytecode_exec_unit_if bus ();

  bytecode_exec_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {isaluop, iscmp, cmptype, isargpush, isgoto, argc, stackargs, stackwb, constpush}
  function automatic logic [13:0] flags();
    return {bus.isaluop, bus.iscmp, bus.cmptype, bus.isargpush, bus.isgoto,
            bus.argc, bus.stackargs, bus.stackwb, bus.constpush};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op_code   = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    step(8'h60, 32'h1234_5678, 32'h1111_1111);
    check("rst_flags", 32'(flags()), 32'h0);
    check("rst_aluop", 32'(bus.aluop), 32'h0);
    check("rst_constval", bus.constval, 32'h0);
    check("rst_lo", bus.result_lo, 32'h0);
    check("rst_hi", bus.result_hi, 32'h0);

    rst_n = 1'b1;
    step(8'h02, 32'h0, 32'h0);
    check("iconst_m1_flags", 32'(flags()), 32'({1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1}));
    check("iconst_m1_val", bus.constval, 32'hffff_ffff);

    step(8'h08, 32'h0, 32'h0);
    check("iconst_5_val", bus.constval, 32'd5);

    step(8'h10, 32'h0, 32'h0);
    check("bipush_flags", 32'(flags()), 32'({1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0}));

    step(8'h11, 32'h0, 32'h0);
    check("sipush_flags", 32'(flags()), 32'({1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0}));

    step(8'h60, 32'h7fff_ffff, 32'd1);
    check("iadd_flags", 32'(flags()), 32'({1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0}));
    check("iadd_lo", bus.result_lo, 32'h8000_0000);

    step(8'h64, 32'd3, 32'd5);
    check("isub_aluop", 32'(bus.aluop), 32'd1);
    check("isub_lo", bus.result_lo, 32'hffff_fffe);

    step(8'h68, 32'h7fff_ffff, 32'd2);
    check("imul_pos_lo", bus.result_lo, 32'hffff_fffe);
    check("imul_pos_hi", bus.result_hi, 32'h0);

    step(8'h68, 32'hffff_fffd, 32'd5);
    check("imul_neg_lo", bus.result_lo, 32'hffff_fff1);
    check("imul_neg_hi", bus.result_hi, 32'hffff_ffff);

    step(8'h6c, 32'hffff_fff9, 32'd2);
    check("idiv_lo", bus.result_lo, 32'hffff_fffd);
    check("idiv_hi", bus.result_hi, 32'hffff_ffff);

    step(8'h6c, 32'd7, 32'hffff_fffe);
    check("idiv_negb_lo", bus.result_lo, 32'hffff_fffd);
    check("idiv_negb_hi", bus.result_hi, 32'd1);

    step(8'h6c, 32'd5, 32'd0);
    check("idiv_zero_lo", bus.result_lo, 32'h0);
    check("idiv_zero_hi", bus.result_hi, 32'h0);

    step(8'h6c, 32'h8000_0000, 32'hffff_ffff);
    check("idiv_ovf_lo", bus.result_lo, 32'h8000_0000);
    check("idiv_ovf_hi", bus.result_hi, 32'h0);

    step(8'h70, 32'hffff_fff9, 32'd2);
    check("irem_lo", bus.result_lo, 32'hffff_ffff);
    check("irem_hi", bus.result_hi, 32'h0);

    step(8'h70, 32'h8000_0000, 32'hffff_ffff);
    check("irem_ovf_lo", bus.result_lo, 32'h0);

    step(8'h70, 32'd9, 32'd0);
    check("irem_zero_lo", bus.result_lo, 32'h0);

    step(8'h74, 32'd5, 32'd0);
    check("ineg_stackargs", 32'(bus.stackargs), 32'd1);
    check("ineg_lo", bus.result_lo, 32'hffff_fffb);

    step(8'h78, 32'd1, 32'h21);
    check("ishl_lo", bus.result_lo, 32'd2);

    step(8'h7a, 32'h8000_0000, 32'd33);
    check("ishr_lo", bus.result_lo, 32'hc000_0000);

    step(8'h7c, 32'h8000_0000, 32'd33);
    check("iushr_lo", bus.result_lo, 32'h4000_0000);

    step(8'h7e, 32'hf0f0_ff00, 32'h0ff0_f0f0);
    check("iand_lo", bus.result_lo, 32'h00f0_f000);
    step(8'h80, 32'hf0f0_ff00, 32'h0ff0_f0f0);
    check("ior_lo", bus.result_lo, 32'hfff0_fff0);
    step(8'h82, 32'hf0f0_ff00, 32'h0ff0_f0f0);
    check("ixor_lo", bus.result_lo, 32'hff00_0ff0);
    check("ixor_aluop", 32'(bus.aluop), 32'd11);

    step(8'h9b, 32'h0, 32'h0);
    check("iflt_flags", 32'(flags()), 32'({1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0}));

    step(8'h9e, 32'h0, 32'h0);
    check("ifle_cmptype", 32'(bus.cmptype), 32'b0011);

    step(8'ha4, 32'h0, 32'h0);
    check("icmple_flags", 32'(flags()), 32'({1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0}));

    step(8'ha2, 32'h0, 32'h0);
    check("icmpge_cmptype", 32'(bus.cmptype), 32'b1100);

    step(8'ha7, 32'h0, 32'h0);
    check("goto_flags", 32'(flags()), 32'({1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0}));

    step(8'hff, 32'h1234_5678, 32'h9abc_def0);
    check("ff_flags", 32'(flags()), 32'h0);
    check("ff_aluop", 32'(bus.aluop), 32'h0);
    check("ff_constval", bus.constval, 32'h0);

    step(8'h00, 32'h0, 32'h0);
    check("nop_flags", 32'(flags()), 32'h0);

    // Reset must win over a valid ALU opcode presented in the same cycle.
    rst_n = 1'b0;
    step(8'h68, 32'hffff_fffd, 32'd5);
    check("rst2_flags", 32'(flags()), 32'h0);
    check("rst2_lo", bus.result_lo, 32'h0);
    check("rst2_hi", bus.result_hi, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
